// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one single-port memory between the instruction-fetch
//                requester and the load/store requester. Each transaction
//                runs IDLE -> ACCESS -> (WAIT) -> ACK. Data has priority over
//                fetch, bounded by a starvation limit for fetch.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int AW      = 8,
    parameter int DW      = 16,
    parameter int MEM_LAT = 1,
    parameter int MAX_DM  = 3
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          IfReq,
    input  logic [AW-1:0] IfAddr,
    output logic          IfAck,
    output logic [DW-1:0] IfData,
    input  logic          DmReq,
    input  logic          DmWe,
    input  logic [AW-1:0] DmAddr,
    input  logic [DW-1:0] DmWrData,
    output logic          DmAck,
    output logic [DW-1:0] DmRdData,
    output logic          MemEn,
    output logic          MemWe,
    output logic [AW-1:0] MemAddr,
    output logic [DW-1:0] MemWrData,
    input  logic [DW-1:0] MemRdData,
    output logic          FetchWait,
    output logic          Busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_ACK    = 2'd3
    } state_t;

    // Number of data grants fetch may lose in a row before it wins
    localparam logic [3:0] c_MAX_DM     = 4'(MAX_DM);
    localparam logic [3:0] c_STREAK_SAT = 4'd15;
    // Latency 1 goes straight from ACCESS to ACK; otherwise WAIT burns the rest
    localparam bit         c_HAS_WAIT   = (MEM_LAT > 1);
    localparam logic [1:0] c_LAT_LOAD   = (MEM_LAT > 1) ? 2'(MEM_LAT - 2) : 2'd0;

    state_t          r_state;
    state_t          w_next_state;
    logic            w_grant_if;
    logic            w_grant_dm;
    logic            r_owner_dm;
    logic [AW-1:0]   r_addr;
    logic            r_we;
    logic [DW-1:0]   r_wdata;
    logic [3:0]      r_streak;
    logic [1:0]      r_lat;

    // State register; reset aborts any transaction in flight without an Ack
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Arbitration, next-state and all port outputs derived from the state
    always_comb begin
        w_next_state = r_state;
        w_grant_if   = 1'b0;
        w_grant_dm   = 1'b0;
        MemEn        = 1'b0;
        MemWe        = 1'b0;
        MemAddr      = '0;
        MemWrData    = '0;
        IfAck        = 1'b0;
        DmAck        = 1'b0;
        IfData       = '0;
        DmRdData     = '0;

        case (r_state)
            S_IDLE: begin
                // Data wins unless fetch has already lost MAX_DM times in a row
                if (DmReq && !(IfReq && (r_streak == c_MAX_DM))) begin
                    w_grant_dm   = 1'b1;
                    w_next_state = S_ACCESS;
                end else if (IfReq) begin
                    w_grant_if   = 1'b1;
                    w_next_state = S_ACCESS;
                end
            end
            S_ACCESS: begin
                MemEn        = 1'b1;
                MemWe        = r_we;
                MemAddr      = r_addr;
                MemWrData    = r_wdata;
                w_next_state = c_HAS_WAIT ? S_WAIT : S_ACK;
            end
            S_WAIT: begin
                if (r_lat == 2'd0) begin
                    w_next_state = S_ACK;
                end
            end
            S_ACK: begin
                // Read data is passed straight through in the Ack cycle only
                if (r_owner_dm) begin
                    DmAck    = 1'b1;
                    DmRdData = MemRdData;
                end else begin
                    IfAck    = 1'b1;
                    IfData   = MemRdData;
                end
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Capture the granted request; loads always carry We=0 and no write data
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_owner_dm <= 1'b0;
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_wdata    <= '0;
        end else if (w_grant_dm) begin
            r_owner_dm <= 1'b1;
            r_addr     <= DmAddr;
            r_we       <= DmWe;
            r_wdata    <= DmWe ? DmWrData : '0;
        end else if (w_grant_if) begin
            r_owner_dm <= 1'b0;
            r_addr     <= IfAddr;
            r_we       <= 1'b0;
            r_wdata    <= '0;
        end
    end

    // Count data grants that were taken while fetch was waiting
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_streak <= 4'd0;
        end else if (w_grant_dm) begin
            if (IfReq) begin
                if (r_streak != c_STREAK_SAT) begin
                    r_streak <= r_streak + 4'd1;
                end
            end else begin
                r_streak <= 4'd0;
            end
        end else if (w_grant_if) begin
            r_streak <= 4'd0;
        end
    end

    // Latency counter: loaded leaving ACCESS, counts down through WAIT
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_lat <= 2'd0;
        end else if (r_state == S_ACCESS) begin
            r_lat <= c_LAT_LOAD;
        end else if ((r_state == S_WAIT) && (r_lat != 2'd0)) begin
            r_lat <= r_lat - 2'd1;
        end
    end

    assign FetchWait = IfReq & ~IfAck;
    assign Busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Four arbiters with MEM_LAT 1..4, each with its own memory
//                model. Stimulus pushes expected Acks into per-instance
//                queues; a monitor pops and compares on every Ack.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    typedef struct packed {
        logic        dm;
        logic        chkd;
        logic [15:0] data;
    } exp_t;

    logic        CLK;
    logic        rst        [4];
    logic        if_req     [4];
    logic [7:0]  if_addr    [4];
    logic        if_ack     [4];
    logic [15:0] if_data    [4];
    logic        dm_req     [4];
    logic        dm_we      [4];
    logic [7:0]  dm_addr    [4];
    logic [15:0] dm_wd      [4];
    logic        dm_ack     [4];
    logic [15:0] dm_rd      [4];
    logic        mem_en     [4];
    logic        mem_we     [4];
    logic [7:0]  mem_addr   [4];
    logic [15:0] mem_wd     [4];
    logic        fetch_wait [4];
    logic        busy       [4];

    logic [15:0] mem [4][256];
    logic [15:0] rdp [4][4];
    logic        mem_init;

    exp_t exp_q [4][$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   men_cnt [4];
    int   men_cyc [4];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        mem_port_arbiter #(
            .AW(8), .DW(16), .MEM_LAT(g + 1), .MAX_DM(3)
        ) u_dut (
            .CLK(CLK), .RST(rst[g]),
            .IfReq(if_req[g]), .IfAddr(if_addr[g]), .IfAck(if_ack[g]), .IfData(if_data[g]),
            .DmReq(dm_req[g]), .DmWe(dm_we[g]), .DmAddr(dm_addr[g]), .DmWrData(dm_wd[g]),
            .DmAck(dm_ack[g]), .DmRdData(dm_rd[g]),
            .MemEn(mem_en[g]), .MemWe(mem_we[g]), .MemAddr(mem_addr[g]), .MemWrData(mem_wd[g]),
            .MemRdData(rdp[g][g]),
            .FetchWait(fetch_wait[g]), .Busy(busy[g])
        );
    end

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [15:0] init_val(input logic [7:0] a);
        case (a)
            8'h10:   return 16'h1234;
            8'h30:   return 16'hC0DE;
            8'h40:   return 16'hD00D;
            default: return {a, ~a};
        endcase
    endfunction

    // Memory model: write in the MemEn cycle, read data valid MEM_LAT cycles later
    always @(posedge CLK) begin
        for (int k = 0; k < 4; k++) begin
            if (mem_init) begin
                for (int a = 0; a < 256; a++) mem[k][a] <= init_val(8'(a));
            end else if (mem_en[k] && mem_we[k]) begin
                mem[k][mem_addr[k]] <= mem_wd[k];
            end
            rdp[k][0] <= mem[k][mem_addr[k]];
            for (int s = 1; s < 4; s++) rdp[k][s] <= rdp[k][s-1];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: every Ack is matched against the scoreboard and its MemEn
    always @(negedge CLK) begin : mon
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            if (rst[k]) begin
                men_cnt[k] = 0;
            end else begin
                if (mem_en[k]) begin
                    men_cnt[k] = men_cnt[k] + 1;
                    men_cyc[k] = cyc;
                end
                if (if_ack[k] || dm_ack[k]) begin
                    if (exp_q[k].size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_ack inst %0d: got ack, expected none", k);
                    end else begin
                        e = exp_q[k].pop_front();
                        chk($sformatf("ack_owner[%0d]", k), {30'd0, if_ack[k], dm_ack[k]},
                            e.dm ? 32'd1 : 32'd2);
                        if (e.chkd) begin
                            chk($sformatf("ack_data[%0d]", k),
                                {16'd0, (e.dm ? dm_rd[k] : if_data[k])}, {16'd0, e.data});
                        end
                        chk($sformatf("ack_latency[%0d]", k), cyc - men_cyc[k], k + 1);
                        chk($sformatf("memen_count[%0d]", k), men_cnt[k], 1);
                        men_cnt[k] = 0;
                    end
                end
            end
        end
    end

    // Holds the caller's request until Ack, then returns in the following cycle
    task automatic wait_ack(input int k, input bit dm);
        bit seen = 1'b0;
        for (int c = 0; c < 16 && !seen; c++) begin
            @(negedge CLK);
            seen = dm ? dm_ack[k] : if_ack[k];
            @(posedge CLK); #1;
        end
        if (!seen) begin
            n_cmp++;
            n_fail++;
            $display("FAIL ack_timeout inst %0d: got no ack, expected ack", k);
        end
    endtask

    task automatic if_txn(input int k, input logic [7:0] a, input logic [15:0] d);
        exp_t e;
        e.dm = 1'b0; e.chkd = 1'b1; e.data = d;
        exp_q[k].push_back(e);
        @(posedge CLK); #1;
        if_req[k] = 1'b1; if_addr[k] = a;
        wait_ack(k, 1'b0);
        if_req[k] = 1'b0;
    endtask

    task automatic dm_txn(input int k, input logic we, input logic [7:0] a,
                          input logic [15:0] wd, input logic [15:0] d);
        exp_t e;
        e.dm = 1'b1; e.chkd = !we; e.data = d;
        exp_q[k].push_back(e);
        @(posedge CLK); #1;
        dm_req[k] = 1'b1; dm_we[k] = we; dm_addr[k] = a; dm_wd[k] = wd;
        wait_ack(k, 1'b1);
        dm_req[k] = 1'b0; dm_we[k] = 1'b0;
    endtask

    // Both requesters held high for n grants; pat bit j set = grant j goes to fetch
    task automatic contend(input int k, input int lat, input int n, input logic [15:0] pat);
        exp_t e;
        int   p = lat + 2;
        bit   ackc;
        for (int j = 0; j < n; j++) begin
            e.dm = !pat[j]; e.chkd = 1'b1; e.data = pat[j] ? 16'hC0DE : 16'hD00D;
            exp_q[k].push_back(e);
        end
        @(posedge CLK); #1;
        if_req[k] = 1'b1; if_addr[k] = 8'h30;
        dm_req[k] = 1'b1; dm_we[k] = 1'b0; dm_addr[k] = 8'h40;
        for (int c = 0; c < p * n; c++) begin
            @(negedge CLK);
            ackc = ((c % p) == (lat + 1));
            chk($sformatf("fetchwait[%0d] c%0d", k, c), {31'd0, fetch_wait[k]},
                {31'd0, !(ackc && pat[c / p])});
            @(posedge CLK); #1;
        end
        if_req[k] = 1'b0; dm_req[k] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        mem_init = 1'b1;
        for (int k = 0; k < 4; k++) begin
            rst[k] = 1'b1; if_req[k] = 1'b0; if_addr[k] = 8'h0;
            dm_req[k] = 1'b0; dm_we[k] = 1'b0; dm_addr[k] = 8'h0; dm_wd[k] = 16'h0;
            men_cnt[k] = 0; men_cyc[k] = 0;
        end

        // Reset state; FetchWait follows IfReq even in reset
        repeat (2) @(posedge CLK);
        #1 if_req[0] = 1'b1;
        @(negedge CLK);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rst_busy[%0d]", k), {31'd0, busy[k]}, 0);
            chk($sformatf("rst_memen[%0d]", k), {31'd0, mem_en[k]}, 0);
            chk($sformatf("rst_acks[%0d]", k), {30'd0, if_ack[k], dm_ack[k]}, 0);
            chk($sformatf("rst_memaddr[%0d]", k), {24'd0, mem_addr[k]}, 0);
            chk($sformatf("rst_data[%0d]", k), {if_data[k], dm_rd[k]}, 0);
        end
        chk("rst_fetchwait", {31'd0, fetch_wait[0]}, 1);
        chk("rst_fetchwait_idle", {31'd0, fetch_wait[1]}, 0);
        @(posedge CLK); #1;
        if_req[0] = 1'b0; mem_init = 1'b0;
        for (int k = 0; k < 4; k++) rst[k] = 1'b0;

        // Single fetch, MEM_LAT=1
        exp_q[0].push_back('{dm: 1'b0, chkd: 1'b1, data: 16'h1234});
        @(posedge CLK); #1;
        if_req[0] = 1'b1; if_addr[0] = 8'h10;
        @(negedge CLK);
        chk("f1_c0_memen", {31'd0, mem_en[0]}, 0);
        @(posedge CLK); #1; @(negedge CLK);
        chk("f1_c1_memen", {31'd0, mem_en[0]}, 1);
        chk("f1_c1_memaddr", {24'd0, mem_addr[0]}, 32'h10);
        chk("f1_c1_memwe", {31'd0, mem_we[0]}, 0);
        @(posedge CLK); #1; @(negedge CLK);
        chk("f1_c2_ifack", {31'd0, if_ack[0]}, 1);
        chk("f1_c2_ifdata", {16'd0, if_data[0]}, 32'h1234);
        @(posedge CLK); #1;
        if_req[0] = 1'b0;
        @(negedge CLK);
        chk("f1_c3_busy", {31'd0, busy[0]}, 0);
        chk("f1_c3_ifdata", {16'd0, if_data[0]}, 0);

        // Store then load, MEM_LAT=3
        exp_q[2].push_back('{dm: 1'b1, chkd: 1'b0, data: 16'h0});
        @(posedge CLK); #1;
        dm_req[2] = 1'b1; dm_we[2] = 1'b1; dm_addr[2] = 8'h20; dm_wd[2] = 16'hBEEF;
        @(posedge CLK); #1; @(negedge CLK);
        chk("st_c1_memen", {31'd0, mem_en[2]}, 1);
        chk("st_c1_memwe", {31'd0, mem_we[2]}, 1);
        chk("st_c1_memaddr", {24'd0, mem_addr[2]}, 32'h20);
        chk("st_c1_memwd", {16'd0, mem_wd[2]}, 32'hBEEF);
        for (int c = 2; c < 4; c++) begin
            @(posedge CLK); #1; @(negedge CLK);
            chk($sformatf("st_c%0d_dmack", c), {31'd0, dm_ack[2]}, 0);
            chk($sformatf("st_c%0d_memwd", c), {16'd0, mem_wd[2]}, 0);
        end
        @(posedge CLK); #1; @(negedge CLK);
        chk("st_c4_dmack", {31'd0, dm_ack[2]}, 1);
        @(posedge CLK); #1;
        dm_req[2] = 1'b0; dm_we[2] = 1'b0;
        dm_txn(2, 1'b0, 8'h20, 16'h0, 16'hBEEF);

        // Contention, MAX_DM=3, MEM_LAT=1: DM DM DM IF DM DM DM IF
        contend(0, 1, 8, 16'b1000_1000);

        // Streak clear: leave streak at 2, clear it with a lone DM grant
        contend(1, 2, 6, 16'b00_1000);
        dm_txn(1, 1'b0, 8'h40, 16'h0, 16'hD00D);
        contend(1, 2, 4, 16'b1000);

        // Reset during WAIT, MEM_LAT=4
        @(posedge CLK); #1;
        if_req[3] = 1'b1; if_addr[3] = 8'h30;
        @(posedge CLK); #1; @(negedge CLK);
        chk("rw_c1_memen", {31'd0, mem_en[3]}, 1);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        rst[3] = 1'b1; if_req[3] = 1'b0;
        @(negedge CLK);
        chk("rw_c3_busy", {31'd0, busy[3]}, 1);
        @(posedge CLK); #1;
        rst[3] = 1'b0;
        @(negedge CLK);
        chk("rw_c4_busy", {31'd0, busy[3]}, 0);
        chk("rw_c4_memen", {31'd0, mem_en[3]}, 0);
        for (int c = 5; c < 8; c++) begin
            @(posedge CLK); #1; @(negedge CLK);
            chk($sformatf("rw_c%0d_ifack", c), {31'd0, if_ack[3]}, 0);
        end
        if_txn(3, 8'h10, 16'h1234);

        // Latency sweep across all four instances
        for (int k = 0; k < 4; k++) begin
            if_txn(k, 8'h10, 16'h1234);
            dm_txn(k, 1'b0, 8'h30, 16'h0, 16'hC0DE);
        end

        repeat (4) @(posedge CLK);
        @(negedge CLK);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("queue_empty[%0d]", k), exp_q[k].size(), 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
